// File: rtl/rtc_bus_responder.sv
// BCD real-time clock behind an asynchronous multiplexed address/data bus.
// Bus pins are double-flopped; an 8-bit address latch selects time/control registers.
module rtc_bus_responder (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs,
   input  logic       ad,
   input  logic       wr,
   input  logic       rd,
   input  logic [7:0] ADin,
   input  logic       tick,
   output logic [7:0] ADout,
   output logic       ADoe,
   output logic       err
);
   typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_t;

   // {cs, ad, wr, rd, ADin} as seen on an idle bus
   localparam logic [11:0] BUS_IDLE = 12'hB00;
   // index 0..5 = seconds, minutes, hours, day, month, year
   localparam logic [5:0][7:0] MAXV = {8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59};
   localparam logic [5:0][7:0] MINV = {8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};

   logic [11:0]     sync1, sync2;
   logic            cs_s, ad_s, wr_s, rd_s, wr_q, wr_rise;
   logic [7:0]      din_s;
   state_t          state, state_n;
   logic [7:0]      addr;
   logic [5:0][7:0] tr;
   logic            stop;
   logic            coll_q;
   logic            wr_en, addr_ld, coll, rd_entry, wr_ok;
   logic [7:0]      rmux;
   logic            rmap;
   logic [5:0]      hit, cy;

   assign {cs_s, ad_s, wr_s, rd_s, din_s} = sync2;
   assign wr_rise = wr_s & ~wr_q;

   function automatic logic bcd_ok(input logic [7:0] d);
      return (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9);
   endfunction

   function automatic logic wr_valid(input logic [7:0] a, input logic [7:0] d);
      case (a)
         8'h21, 8'h22: return bcd_ok(d) && (d <= 8'h59);
         8'h23:        return bcd_ok(d) && (d <= 8'h23);
         8'h24:        return bcd_ok(d) && (d != 8'h00) && (d <= 8'h31);
         8'h25:        return bcd_ok(d) && (d != 8'h00) && (d <= 8'h12);
         8'h26:        return bcd_ok(d);
         8'h02:        return 1'b1;
         default:      return 1'b0;
      endcase
   endfunction

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] mx,
                                          input logic [7:0] mn);
      if (v == mx) return mn;
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return v + 8'd1;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= BUS_IDLE;
         sync2 <= BUS_IDLE;
         wr_q  <= 1'b1;
      end else begin
         sync1 <= {cs, ad, wr, rd, ADin};
         sync2 <= sync1;
         wr_q  <= wr_s;
      end
   end

   always_comb begin
      state_n  = state;
      wr_en    = 1'b0;
      addr_ld  = 1'b0;
      coll     = 1'b0;
      rd_entry = 1'b0;
      case (state)
         IDLE:
            if (!cs_s) begin
               if (!wr_s && !rd_s) coll = 1'b1;
               else if (!wr_s) state_n = ad_s ? WDATA : ADDR;
               else if (ad_s && !rd_s) begin
                  state_n  = RDATA;
                  rd_entry = 1'b1;
               end
            end
         ADDR:
            if (wr_rise) begin
               addr_ld = 1'b1;
               state_n = IDLE;
            end else if (cs_s) state_n = IDLE;
         WDATA:
            if (wr_rise) begin
               wr_en   = 1'b1;
               state_n = IDLE;
            end else if (cs_s) state_n = IDLE;
         RDATA:
            if (rd_s || cs_s) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      rmux = 8'h00;
      rmap = 1'b1;
      case (addr)
         8'h21:   rmux = tr[0];
         8'h22:   rmux = tr[1];
         8'h23:   rmux = tr[2];
         8'h24:   rmux = tr[3];
         8'h25:   rmux = tr[4];
         8'h26:   rmux = tr[5];
         8'h02:   rmux = {7'b0, stop};
         default: rmap = 1'b0;
      endcase
   end

   // A bus write to a time register wins over the tick and blocks its carry upward
   always_comb begin
      wr_ok = wr_valid(addr, din_s);
      for (int k = 0; k < 6; k++)
         hit[k] = wr_en && wr_ok && (addr == 8'(33 + k));
      cy[0] = tick & ~stop;
      for (int k = 1; k < 6; k++)
         cy[k] = cy[k-1] & (tr[k-1] == MAXV[k-1]) & ~hit[k-1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr <= 8'h00;
         tr   <= MINV;
         stop <= 1'b0;
      end else begin
         if (addr_ld) addr <= din_s;
         if (wr_en && wr_ok && (addr == 8'h02)) stop <= din_s[0];
         for (int k = 0; k < 6; k++) begin
            if (hit[k]) tr[k] <= din_s;
            else if (cy[k]) tr[k] <= bcd_inc(tr[k], MAXV[k], MINV[k]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         ADout  <= 8'h00;
         ADoe   <= 1'b0;
         err    <= 1'b0;
         coll_q <= 1'b0;
      end else begin
         state  <= state_n;
         coll_q <= coll;
         // a held wr/rd collision reports only on its first cycle
         err    <= (coll & ~coll_q) | (wr_en & ~wr_ok) | (rd_entry & ~rmap);
         if (state == RDATA && !(rd_s || cs_s)) begin
            ADoe  <= 1'b1;
            ADout <= rmux;
         end else begin
            ADoe  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed plus randomized bus traffic against a calendar-arithmetic model of the RTC.
module tb_rtc_bus_responder;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cs = 1'b1, ad = 1'b0, wr = 1'b1, rd = 1'b1, tick = 1'b0;
   logic [7:0] ADin = 8'h00;
   logic [7:0] ADout;
   logic       ADoe, err;

   rtc_bus_responder dut (
      .clk(clk), .rst(rst), .cs(cs), .ad(ad), .wr(wr), .rd(rd),
      .ADin(ADin), .tick(tick), .ADout(ADout), .ADoe(ADoe), .err(err)
   );

   always #5 clk = ~clk;

   int nvec = 0, nfail = 0, err_cnt = 0;
   always @(negedge clk) if (err === 1'b1) err_cnt++;

   // reference model: time fields as plain integers
   int t[6];
   bit stop;
   int MAXB[6] = '{59, 59, 23, 31, 12, 99};
   int MINB[6] = '{0, 0, 0, 1, 1, 0};

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      t = '{0, 0, 0, 1, 1, 0};
      stop = 1'b0;
   endtask

   function automatic int m_idx(input logic [7:0] a);
      if (a >= 8'h21 && a <= 8'h26) return int'(a) - 33;
      if (a == 8'h02) return 6;
      return -1;
   endfunction

   function automatic logic [7:0] bcd(input int n);
      return 8'((n / 10) * 16 + (n % 10));
   endfunction

   function automatic bit m_valid(input logic [7:0] a, input logic [7:0] d, output int v);
      int idx;
      int hi, lo;
      idx = m_idx(a);
      hi  = int'(d[7:4]);
      lo  = int'(d[3:0]);
      v   = hi * 10 + lo;
      if (idx < 0) return 1'b0;
      if (idx == 6) return 1'b1;
      if (hi > 9 || lo > 9) return 1'b0;
      return (v >= MINB[idx]) && (v <= MAXB[idx]);
   endfunction

   task automatic m_step(input bit tk, input bit w, input logic [7:0] a, input logic [7:0] d,
                         output int experr);
      int nt[6];
      int v, idx;
      bit ok;
      nt = t;
      if (tk && !stop) begin
         nt[0]++;
         for (int k = 0; k < 6; k++)
            if (nt[k] > MAXB[k]) begin
               nt[k] = MINB[k];
               if (k < 5) nt[k+1]++;
            end
      end
      experr = 0;
      if (w) begin
         idx = m_idx(a);
         ok = m_valid(a, d, v);
         experr = ok ? 0 : 1;
         if (ok && idx >= 0 && idx < 6)
            for (int k = idx; k < 6; k++) nt[k] = (k == idx) ? v : t[k];
         if (ok && idx == 6) stop = d[0];
      end
      t = nt;
   endtask

   function automatic logic [7:0] m_read(input logic [7:0] a);
      int idx;
      idx = m_idx(a);
      if (idx < 0) return 8'h00;
      if (idx == 6) return {7'b0, stop};
      return bcd(t[idx]);
   endfunction

   task automatic addr_phase(input logic [7:0] a);
      @(negedge clk); cs = 1'b0; ad = 1'b0; ADin = a; wr = 1'b0;
      repeat (4) @(negedge clk); wr = 1'b1;
      repeat (4) @(negedge clk); cs = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // tk lines the tick up with the clock edge that commits the write
   task automatic bus_write(input logic [7:0] a, input logic [7:0] d, input bit tk);
      addr_phase(a);
      @(negedge clk); cs = 1'b0; ad = 1'b1; ADin = d; wr = 1'b0;
      repeat (4) @(negedge clk); wr = 1'b1;
      if (tk) begin
         repeat (2) @(negedge clk); tick = 1'b1;
         @(negedge clk); tick = 1'b0;
         @(negedge clk);
      end else repeat (4) @(negedge clk);
      cs = 1'b1; ad = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic oe);
      addr_phase(a);
      @(negedge clk); cs = 1'b0; ad = 1'b1; rd = 1'b0;
      repeat (6) @(negedge clk);
      d = ADout; oe = ADoe;
      rd = 1'b1; cs = 1'b1; ad = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic wr_op(input logic [7:0] a, input logic [7:0] d, input bit tk);
      int e0, ee;
      e0 = err_cnt;
      bus_write(a, d, tk);
      m_step(tk, 1'b1, a, d, ee);
      chk($sformatf("wr_err@%02h=%02h", a, d), 8'(err_cnt - e0), 8'(ee));
   endtask

   task automatic rd_chk(input logic [7:0] a);
      logic [7:0] d;
      logic oe;
      int e0;
      e0 = err_cnt;
      bus_read(a, d, oe);
      chk($sformatf("rd_data@%02h", a), d, m_read(a));
      chk($sformatf("rd_oe@%02h", a), {7'b0, oe}, 8'h01);
      chk($sformatf("rd_err@%02h", a), 8'(err_cnt - e0), (m_idx(a) < 0) ? 8'h01 : 8'h00);
      chk($sformatf("oe_off@%02h", a), {7'b0, ADoe}, 8'h00);
      chk($sformatf("out_hold@%02h", a), ADout, d);
   endtask

   task automatic do_tick();
      int ee;
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      m_step(1'b1, 1'b0, 8'h00, 8'h00, ee);
   endtask

   task automatic rd_all();
      for (int k = 0; k < 6; k++) rd_chk(8'(33 + k));
      rd_chk(8'h02);
   endtask

   initial begin
      logic [7:0] a, d, rv;
      logic oe;
      int e0, idx;
      m_reset();
      #1;
      chk("rst_ADout", ADout, 8'h00);
      chk("rst_ADoe", {7'b0, ADoe}, 8'h00);
      chk("rst_err", {7'b0, err}, 8'h00);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rd_all();

      // minutes write/readback
      e0 = err_cnt;
      wr_op(8'h22, 8'h45, 1'b0);
      bus_read(8'h22, rv, oe);
      chk("min45_data", rv, 8'h45);
      chk("min45_oe", {7'b0, oe}, 8'h01);
      chk("min45_noerr", 8'(err_cnt - e0), 8'h00);

      // rejected writes
      wr_op(8'h21, 8'h5A, 1'b0);
      rd_chk(8'h21);
      wr_op(8'h22, 8'h60, 1'b0);
      rd_chk(8'h22);
      wr_op(8'h7F, 8'h12, 1'b0);

      // stop bit
      wr_op(8'h21, 8'h17, 1'b0);
      wr_op(8'h02, 8'h01, 1'b0);
      rd_chk(8'h02);
      repeat (5) do_tick();
      rd_chk(8'h21);
      wr_op(8'h02, 8'h00, 1'b0);
      do_tick();
      bus_read(8'h21, rv, oe);
      chk("sec_after_run", rv, 8'h18);

      // write coincident with tick
      wr_op(8'h22, 8'h07, 1'b0);
      wr_op(8'h21, 8'h59, 1'b0);
      wr_op(8'h21, 8'h10, 1'b1);
      bus_read(8'h21, rv, oe);
      chk("sec_wr_wins", rv, 8'h10);
      bus_read(8'h22, rv, oe);
      chk("min_no_carry", rv, 8'h07);

      // full rollover
      wr_op(8'h21, 8'h59, 1'b0);
      wr_op(8'h22, 8'h59, 1'b0);
      wr_op(8'h23, 8'h23, 1'b0);
      wr_op(8'h24, 8'h31, 1'b0);
      wr_op(8'h25, 8'h12, 1'b0);
      wr_op(8'h26, 8'h99, 1'b0);
      do_tick();
      rd_all();

      // wr and rd low together: one err pulse however long it is held
      e0 = err_cnt;
      @(negedge clk); cs = 1'b0; ad = 1'b1; wr = 1'b0; rd = 1'b0;
      repeat (8) @(negedge clk); wr = 1'b1; rd = 1'b1;
      repeat (2) @(negedge clk); cs = 1'b1; ad = 1'b0;
      repeat (3) @(negedge clk);
      chk("collision_err", 8'(err_cnt - e0), 8'h01);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         case ($urandom % 9)
            0, 1, 2, 3, 4, 5: a = 8'(33 + ($urandom % 6));
            6:                a = 8'h02;
            default:          a = 8'($urandom % 256);
         endcase
         idx = m_idx(a);
         if (idx >= 0 && idx < 6 && ($urandom % 3) != 0)
            d = bcd(int'($urandom_range(MAXB[idx], MINB[idx])));
         else if (idx == 6)
            d = 8'($urandom % 256) & 8'hFE | 8'(($urandom % 4) == 0);
         else
            d = 8'($urandom % 256);
         case ($urandom % 4)
            0: do_tick();
            1: wr_op(a, d, ($urandom % 3) == 0);
            2: rd_chk(a);
            default: repeat (int'($urandom_range(8, 2))) do_tick();
         endcase
      end
      wr_op(8'h02, 8'h00, 1'b0);
      repeat (3) do_tick();
      rd_all();

      // reset in the middle of a data write
      wr_op(8'h21, 8'h37, 1'b0);
      rd_chk(8'h21);
      addr_phase(8'h21);
      @(negedge clk); cs = 1'b0; ad = 1'b1; ADin = 8'h42; wr = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_ADout", ADout, 8'h00);
      chk("midrst_ADoe", {7'b0, ADoe}, 8'h00);
      chk("midrst_err", {7'b0, err}, 8'h00);
      cs = 1'b1; wr = 1'b1; ad = 1'b0; ADin = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      m_reset();
      repeat (4) @(negedge clk);
      rd_chk(8'h21);
      bus_read(8'h7F, rv, oe);
      chk("unmapped_data", rv, 8'h00);
      rd_all();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
